// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with single-cycle logic/arith ops and iterative
// unsigned multiply (shift-add) and divide (restoring) into HI/LO registers.
// Optional feature macro: ALU_DIV_EN (enables the DIVU state and divider).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] hi,
  output logic             zeroflag
);

  localparam logic [3:0] SEL_AND   = 4'b0000;
  localparam logic [3:0] SEL_OR    = 4'b0001;
  localparam logic [3:0] SEL_ADD   = 4'b0010;
  localparam logic [3:0] SEL_SUB   = 4'b0110;
  localparam logic [3:0] SEL_SLT   = 4'b0111;
  localparam logic [3:0] SEL_NOR   = 4'b1100;
  localparam logic [3:0] SEL_MULTU = 4'b1000;
`ifdef ALU_DIV_EN
  localparam logic [3:0] SEL_DIVU  = 4'b1001;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
`ifdef ALU_DIV_EN
    DIV,
`endif
    MUL
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  work_hi_q, work_hi_d;
  logic [WIDTH-1:0]  work_lo_q, work_lo_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  alu_result;
  logic [WIDTH:0]    mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic              last_step;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_diff;
  logic              div_ge;
  logic [WIDTH-1:0]  rem_next;
  logic [WIDTH-1:0]  quo_next;
`endif

  // State, working registers and architectural outputs; reset returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      mcand_q   <= '0;
      res_q     <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      mcand_q   <= mcand_d;
      res_q     <= res_d;
      hi_q      <= hi_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
    end
  end

  // Single-cycle operation result, straight from the issue-time operands.
  always_comb begin
    alu_result = '0;
    case (sel)
      SEL_AND: alu_result = op1 & op2;
      SEL_OR:  alu_result = op1 | op2;
      SEL_ADD: alu_result = op1 + op2;
      SEL_SUB: alu_result = op1 - op2;
      SEL_SLT: alu_result = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      SEL_NOR: alu_result = ~(op1 | op2);
      default: alu_result = '0;
    endcase
  end

  // One shift-add step: add multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole product right with carry.
  always_comb begin
    mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, work_lo_q[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  // One restoring-divide step; the borrow bit of the trial subtraction
  // decides the quotient bit (a zero divisor always yields a 1).
  always_comb begin
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_ge    = ~div_diff[WIDTH];
    rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {work_lo_q[WIDTH-2:0], div_ge};
  end
`endif

  // Next-state logic: leave IDLE only for multi-cycle ops, return after last step.
  always_comb begin
    state_d   = state_q;
    last_step = (cnt_q == LAST_CNT);
    case (state_q)
      IDLE: begin
        if (start && sel == SEL_MULTU) begin
          state_d = MUL;
`ifdef ALU_DIV_EN
        end else if (start && sel == SEL_DIVU) begin
          state_d = DIV;
`endif
        end
      end
      MUL: if (last_step) state_d = IDLE;
`ifdef ALU_DIV_EN
      DIV: if (last_step) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output updates: capture operands on issue, iterate, and publish
  // results together with done and zeroflag on the completing edge.
  always_comb begin
    cnt_d     = cnt_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    mcand_d   = mcand_q;
    res_d     = res_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sel == SEL_MULTU) begin
            work_hi_d = '0;
            work_lo_d = op2;
            mcand_d   = op1;
            cnt_d     = '0;
`ifdef ALU_DIV_EN
          end else if (sel == SEL_DIVU) begin
            work_hi_d = '0;
            work_lo_d = op1;
            mcand_d   = op2;
            cnt_d     = '0;
`endif
          end else begin
            res_d  = alu_result;
            zero_d = (alu_result == '0);
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        work_hi_d = mul_next[2*WIDTH-1:WIDTH];
        work_lo_d = mul_next[WIDTH-1:0];
        if (last_step) begin
          res_d  = mul_next[WIDTH-1:0];
          hi_d   = mul_next[2*WIDTH-1:WIDTH];
          zero_d = (mul_next[WIDTH-1:0] == '0);
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef ALU_DIV_EN
      DIV: begin
        work_hi_d = rem_next;
        work_lo_d = quo_next;
        if (last_step) begin
          res_d  = quo_next;
          hi_d   = rem_next;
          zero_d = (quo_next == '0);
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign resultado = res_q;
  assign hi        = hi_q;
  assign zeroflag  = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32 and WIDTH=8 instances).
// Exercises the divider when built with ALU_DIV_EN, else its fallback path.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start = 1'b0;
   logic [3:0]  sel = 4'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic        busy;
   logic        done;
   logic [31:0] resultado;
   logic [31:0] hi;
   logic        zeroflag;

   logic        start8 = 1'b0;
   logic [3:0]  sel8 = 4'b0;
   logic [7:0]  op1_8 = '0;
   logic [7:0]  op2_8 = '0;
   logic        busy8;
   logic        done8;
   logic [7:0]  resultado8;
   logic [7:0]  hi8;
   logic        zeroflag8;

   int checks = 0;
   int errors = 0;
   int cycles;
   int busyCycles;
   int doneSeen;

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .sel(sel), .op1(op1), .op2(op2),
      .busy(busy), .done(done), .resultado(resultado), .hi(hi), .zeroflag(zeroflag)
   );

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .sel(sel8), .op1(op1_8), .op2(op2_8),
      .busy(busy8), .done(done8), .resultado(resultado8), .hi(hi8), .zeroflag(zeroflag8)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: count it and report any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one operation on the 32-bit DUT; returns at the negedge after the capture edge.
   task automatic applyStimulus(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      sel   = s;
      op1   = a;
      op2   = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done on the 32-bit DUT, counting cycles and busy cycles.
   task automatic waitDone(input int budget, output int nCycles, output int nBusy);
      nCycles = 0;
      nBusy   = 0;
      while (!done && nCycles < budget) begin
         if (busy) nBusy++;
         @(negedge clk);
         nCycles++;
      end
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_res", resultado, 32'd0);
      checkOutput("rst_hi", hi, 32'd0);
      checkOutput("rst_zero", {31'b0, zeroflag}, 32'd1);
      rst = 1'b0;

      // ADD wraps, carry dropped
      applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'd1);
      checkOutput("add_done", {31'b0, done}, 32'd1);
      checkOutput("add_busy", {31'b0, busy}, 32'd0);
      checkOutput("add_res", resultado, 32'd0);
      checkOutput("add_zero", {31'b0, zeroflag}, 32'd1);
      checkOutput("add_hi", hi, 32'd0);
      @(negedge clk);
      checkOutput("add_done_pulse", {31'b0, done}, 32'd0);

      applyStimulus(4'b0111, 32'd3, 32'd5);
      checkOutput("slt_3_5", resultado, 32'd1);
      checkOutput("slt_3_5_zero", {31'b0, zeroflag}, 32'd0);
      applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'd1);
      checkOutput("slt_unsigned", resultado, 32'd0);
      applyStimulus(4'b0110, 32'd5, 32'd3);
      checkOutput("sub_5_3", resultado, 32'd2);
      applyStimulus(4'b0110, 32'd3, 32'd5);
      checkOutput("sub_wrap", resultado, 32'hFFFF_FFFE);
      applyStimulus(4'b1100, 32'd0, 32'd0);
      checkOutput("nor_res", resultado, 32'hFFFF_FFFF);
      checkOutput("nor_zero", {31'b0, zeroflag}, 32'd0);
      applyStimulus(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
      checkOutput("and_res", resultado, 32'h00F0_1200);
      applyStimulus(4'b0001, 32'hF000_0001, 32'h0000_0F00);
      checkOutput("or_res", resultado, 32'hF000_0F01);
      applyStimulus(4'b0011, 32'd7, 32'd9);
      checkOutput("undef_res", resultado, 32'd0);
      checkOutput("undef_zero", {31'b0, zeroflag}, 32'd1);

      // MULTU with an ignored start pulse part-way through
      applyStimulus(4'b1000, 32'hFFFF_FFFF, 32'd2);
      checkOutput("mul_busy", {31'b0, busy}, 32'd1);
      checkOutput("mul_res_held", resultado, 32'd0);
      repeat (5) @(negedge clk);
      start = 1'b1;
      sel   = 4'b0010;
      op1   = 32'd1;
      op2   = 32'd1;
      @(negedge clk);
      start = 1'b0;
      waitDone(40, cycles, busyCycles);
      checkOutput("mul_cycles", cycles, 32'd26);
      checkOutput("mul_busy_cycles", busyCycles, 32'd26);
      checkOutput("mul_done", {31'b0, done}, 32'd1);
      checkOutput("mul_busy_end", {31'b0, busy}, 32'd0);
      checkOutput("mul_hi", hi, 32'h0000_0001);
      checkOutput("mul_lo", resultado, 32'hFFFF_FFFE);
      checkOutput("mul_zero", {31'b0, zeroflag}, 32'd0);
      @(negedge clk);
      checkOutput("mul_done_pulse", {31'b0, done}, 32'd0);
      checkOutput("mul_no_queue", {31'b0, busy}, 32'd0);

      // Single-cycle ops leave HI untouched
      applyStimulus(4'b0000, 32'h0000_00F0, 32'h0000_00FF);
      checkOutput("and_keep_res", resultado, 32'h0000_00F0);
      checkOutput("and_keep_hi", hi, 32'h0000_0001);

`ifdef ALU_DIV_EN
      applyStimulus(4'b1001, 32'd100, 32'd7);
      waitDone(40, cycles, busyCycles);
      checkOutput("div_cycles", cycles, 32'd32);
      checkOutput("div_busy_cycles", busyCycles, 32'd32);
      checkOutput("div_quo", resultado, 32'd14);
      checkOutput("div_rem", hi, 32'd2);
      applyStimulus(4'b1001, 32'd9, 32'd0);
      waitDone(40, cycles, busyCycles);
      checkOutput("div0_cycles", cycles, 32'd32);
      checkOutput("div0_quo", resultado, 32'hFFFF_FFFF);
      checkOutput("div0_rem", hi, 32'd9);
      checkOutput("div0_zero", {31'b0, zeroflag}, 32'd0);
`else
      applyStimulus(4'b1001, 32'd100, 32'd7);
      checkOutput("nodiv_done", {31'b0, done}, 32'd1);
      checkOutput("nodiv_busy", {31'b0, busy}, 32'd0);
      checkOutput("nodiv_res", resultado, 32'd0);
      checkOutput("nodiv_zero", {31'b0, zeroflag}, 32'd1);
      checkOutput("nodiv_hi", hi, 32'h0000_0001);
`endif

      // Back-to-back: ADD issued in the MULTU done cycle
      applyStimulus(4'b1000, 32'd6, 32'd7);
      waitDone(40, cycles, busyCycles);
      checkOutput("b2b_mul_cycles", cycles, 32'd32);
      checkOutput("b2b_mul_res", resultado, 32'd42);
      checkOutput("b2b_mul_hi", hi, 32'd0);
      start = 1'b1;
      sel   = 4'b0010;
      op1   = 32'd1;
      op2   = 32'd1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b_add_done", {31'b0, done}, 32'd1);
      checkOutput("b2b_add_res", resultado, 32'd2);
      checkOutput("b2b_add_hi", hi, 32'd0);

      // Asynchronous reset during a MULTU
      applyStimulus(4'b1000, 32'hFFFF_FFFF, 32'd3);
      repeat (9) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("arst_busy", {31'b0, busy}, 32'd0);
      checkOutput("arst_res", resultado, 32'd0);
      checkOutput("arst_zero", {31'b0, zeroflag}, 32'd1);
      checkOutput("arst_hi", hi, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) doneSeen++;
      end
      checkOutput("arst_no_done", doneSeen, 32'd0);

      // WIDTH=8 instance: 0xFF * 0xFF
      @(negedge clk);
      start8 = 1'b1;
      sel8   = 4'b1000;
      op1_8  = 8'hFF;
      op2_8  = 8'hFF;
      @(negedge clk);
      start8 = 1'b0;
      cycles = 0;
      while (!done8 && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("w8_cycles", cycles, 32'd8);
      checkOutput("w8_hi", {24'b0, hi8}, 32'h0000_00FE);
      checkOutput("w8_lo", {24'b0, resultado8}, 32'h0000_0001);
      checkOutput("w8_zero", {31'b0, zeroflag8}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational datapath ALU.
- Keeps the existing 4-bit operation encoding and zero flag, and generalises the operand width.
- Adds iterative unsigned multiply and divide with HI/LO result registers.
- Issue uses a start/busy/done handshake, so the multi-cycle control FSM can stall on mult/div.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  issue strobe; sampled only when busy=0
sel  input  4  operation code, sampled with start
op1  input  WIDTH  operand A, sampled with start
op2  input  WIDTH  operand B, sampled with start
busy  output  1  multi-cycle operation in progress
done  output  1  one-cycle pulse: resultado/hi/zeroflag valid from this cycle
resultado  output  WIDTH  result / LO register
hi  output  WIDTH  HI register (mult upper half, div remainder)
zeroflag  output  1  1 when resultado==0, updated together with done

Behaviour:
- Reset: one clock (clk); reset rst is asynchronous, active-high. While rst=1: state=IDLE; busy=0, done=0, resultado=0, hi=0, zeroflag=1; iteration counter=0.
- FSM states: IDLE, MUL, DIV.
- Operand capture: start with busy=0 latches sel/op1/op2 at that edge (edge 0). start while busy=1 is ignored, with no queueing.
- Single-cycle ops, completing at edge 0 (done=1 in the following cycle; state stays IDLE):
  - 0000 AND
  - 0001 OR
  - 0010 ADD, modulo 2^WIDTH, carry dropped
  - 0110 SUB, modulo 2^WIDTH
  - 0111 SLT, unsigned: resultado = (op1<op2) ? 1 : 0, zero-extended
  - 1100 NOR
  - any other code: resultado=0
  - hi is unchanged by all of these.
- 1000 MULTU, unsigned shift-add:
  - IDLE->MUL at edge 0; busy=1.
  - One partial product per edge, edges 1..WIDTH.
  - At edge WIDTH: {hi,resultado} = op1*op2 (2*WIDTH bits exact), MUL->IDLE, busy=0, done=1 for one cycle.
- 1001 DIVU, restoring, unsigned:
  - IDLE->DIV at edge 0; busy=1.
  - One quotient bit per edge, edges 1..WIDTH.
  - At edge WIDTH: resultado=quotient, hi=remainder; DIV->IDLE, busy=0, done=1 for one cycle.
  - op2==0: still WIDTH cycles; resultado = all ones, hi = op1. No trap.
- Intermediate values: resultado/hi keep their previous values while busy=1. Working values live in internal registers only.
- zeroflag: evaluated on the final resultado and updated only on the edge that raises done. Held otherwise.
- done is a single-cycle pulse. A start presented in the done cycle is accepted (back-to-back issue, no bubble).
- Reset mid-operation: immediate return to IDLE with reset values. No done is produced for the aborted op.
- Counter: iteration count runs 0..WIDTH-1. There is no wrap beyond this; it is cleared on entry to MUL/DIV.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: the DIV state and divider datapath are present; 1001 behaves as above.
- Undefined: no divider logic is instantiated. 1001 takes the default single-cycle path: done next cycle, resultado=0, zeroflag=1, hi unchanged, busy never asserted.

Test Plan:
- Reset then ADD, WIDTH=32: op1=0xFFFFFFFF, op2=1 -> done 1 cycle after start, resultado=0, zeroflag=1, hi=0, busy never 1.
- SLT/SUB/NOR: SLT op1=3, op2=5 -> resultado=1. SUB 5-3 -> 2. NOR 0,0 -> 0xFFFFFFFF, zeroflag=0.
- MULTU: op1=0xFFFFFFFF, op2=2 -> busy=1 for 32 cycles; then done, hi=0x00000001, resultado=0xFFFFFFFE. start pulsed mid-op is ignored and the result is unchanged.
- DIVU (ALU_DIV_EN): 100/7 -> resultado=14, hi=2 after 32 cycles. 9/0 -> resultado=0xFFFFFFFF, hi=9.
- Back-to-back: MULTU 6*7, then ADD 1+1 issued in the done cycle -> first done: resultado=42, hi=0; next cycle done: resultado=2, hi=0.
- Async reset at cycle 10 of a MULTU -> outputs zero immediately (zeroflag=1, busy=0), no done. Then WIDTH=8 instance: MULTU 0xFF*0xFF -> hi=0xFE, resultado=0x01 after 8 cycles.
